// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES streaming controller.
// Holds the FSM state enum, default settle times and a counter-width helper.
package aes_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int DEF_SETTLE_DATA = 50;
  localparam int DEF_SETTLE_KEY  = 12;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/aes_out_fifo.sv
// First-word-fall-through output FIFO for {ciphertext, tag} results.
// Head entry is visible on o_dout whenever o_empty is low.
module aes_out_fifo #(
  parameter int W     = 132,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  // An empty FIFO cannot pop, so a same-cycle push into it is never lost.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd];
  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

endmodule

// File: rtl/aes_stream_ctrl.sv
// Valid/ready streaming wrapper around an external settling AES core.
// Holds pt/key to the core for a settle window, then queues {ct, tag}.
module aes_stream_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int BLK_W       = 128,
  parameter int KEY_W       = 128,
  parameter int SETTLE_DATA = DEF_SETTLE_DATA,
  parameter int SETTLE_KEY  = DEF_SETTLE_KEY,
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [BLK_W-1:0] s_data,
  input  logic [KEY_W-1:0] s_key,
  input  logic [TAG_W-1:0] s_tag,
  output logic [BLK_W-1:0] core_pt,
  output logic [KEY_W-1:0] core_key,
  input  logic [BLK_W-1:0] core_ct,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [BLK_W-1:0] m_data,
  output logic [TAG_W-1:0] m_tag,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count
);

  localparam int FW = BLK_W + TAG_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = cnt_w(SETTLE_DATA + SETTLE_KEY - 1);
  localparam logic [CW-1:0] LD_DATA = CW'(SETTLE_DATA - 1);
  localparam logic [CW-1:0] LD_FULL = CW'(SETTLE_DATA + SETTLE_KEY - 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  state_e           r_state;
  state_e           w_next;
  logic [CW-1:0]    r_cnt;
  logic [BLK_W-1:0] r_pt;
  logic [KEY_W-1:0] r_key;
  logic [TAG_W-1:0] r_tag;
  logic             r_key_loaded;
  logic [CNT_W-1:0] r_blk_count;

  logic             w_accept;
  logic             w_done;
  logic             w_key_chg;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [AW:0]      w_count;
  logic [FW-1:0]    w_dout;

  assign s_ready   = (r_state == IDLE) && (w_count < DEPTH_C) && !reset;
  assign w_accept  = s_valid && s_ready;
  assign w_done    = (r_state == WAIT) && (r_cnt == '0);
  assign w_key_chg = !r_key_loaded || (s_key != r_key);
  assign w_push    = w_done && !w_full;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = WAIT;
      WAIT:    if (r_cnt == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Key-change penalty is paid on the first block after reset as well.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_pt         <= '0;
      r_key        <= '0;
      r_tag        <= '0;
      r_key_loaded <= 1'b0;
      r_blk_count  <= '0;
    end else begin
      if (w_accept) begin
        r_pt         <= s_data;
        r_key        <= s_key;
        r_tag        <= s_tag;
        r_cnt        <= w_key_chg ? LD_FULL : LD_DATA;
        r_key_loaded <= 1'b1;
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_push) r_blk_count <= r_blk_count + 1'b1;
    end
  end

  aes_out_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   ({core_ct, r_tag}),
    .i_pop   (m_ready),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign core_pt   = r_pt;
  assign core_key  = r_key;
  assign m_valid   = !w_empty;
  assign m_data    = w_dout[FW-1:TAG_W];
  assign m_tag     = w_dout[TAG_W-1:0];
  assign busy      = (r_state == WAIT);
  assign blk_count = r_blk_count;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: settling-core stand-in, queue-based reference
// model compared every cycle, plus directed scenarios with literal checks.
module tb_aes_stream_ctrl;

  localparam int SD    = 50;
  localparam int SK    = 12;
  localparam int DEPTH = 4;
  localparam int CNTW  = 4;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] GARBAGE = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic [127:0] s_key;
  logic [3:0]   s_tag;
  logic [127:0] core_pt;
  logic [127:0] core_key;
  logic [127:0] core_ct = GARBAGE;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic [3:0]   m_tag;
  logic         busy;
  logic [CNTW-1:0] blk_count;

  int nchk = 0;
  int nerr = 0;
  int ecnt = 0;

  aes_stream_ctrl #(
    .BLK_W(128), .KEY_W(128), .SETTLE_DATA(SD), .SETTLE_KEY(SK),
    .FIFO_DEPTH(DEPTH), .TAG_W(4), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_key(s_key), .s_tag(s_tag),
    .core_pt(core_pt), .core_key(core_key), .core_ct(core_ct),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_tag(m_tag),
    .busy(busy), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  // Stand-in cipher: the known test vector, otherwise a keyed mix.
  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
    if (pt == P1 && key == K1) return C1;
    return pt ^ {key[95:0], key[127:96]} ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
  endfunction

  // Core output is garbage until the inputs have been stable long enough.
  longint t_pt  = -1000000;
  longint t_key = -1000000;
  always @(core_pt)  t_pt  = longint'($time);
  always @(core_key) t_key = longint'($time);
  always @(negedge clk) begin
    longint now;
    now = longint'($time);
    if ((now - t_pt) >= longint'(10*(SD-1)+5) && (now - t_key) >= longint'(10*(SD+SK-1)+5))
      core_ct = core_fn(core_pt, core_key);
    else
      core_ct = GARBAGE;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: one block in flight, result due N edges after accept.
  typedef struct { logic [127:0] ct; logic [3:0] tag; } res_t;
  res_t         q[$];
  int           done_at = -1;
  bit           kl = 0;
  bit           armed = 0;
  int           mblk = 0;
  logic [127:0] mpt = '0;
  logic [127:0] mkey = '0;
  logic [3:0]   mtag = '0;
  int           c;
  bit           mpop, macc;
  int           n;

  always @(posedge clk) begin
    c = ecnt;
    ecnt <= ecnt + 1;
    if (reset) begin
      q.delete();
      done_at = -1; kl = 0; mblk = 0; mpt = '0; mkey = '0; mtag = '0; armed = 1;
    end else if (armed) begin
      mpop = (q.size() > 0) && m_ready;
      macc = s_valid && (done_at < 0) && (q.size() < DEPTH);
      if (mpop) void'(q.pop_front());
      if (done_at == c) begin
        q.push_back('{core_fn(mpt, mkey), mtag});
        mblk++;
        done_at = -1;
      end
      if (macc) begin
        n = SD + ((!kl || s_key != mkey) ? SK : 0);
        done_at = c + n;
        mpt = s_data; mkey = s_key; mtag = s_tag; kl = 1;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (armed) begin
      chk("s_ready", 128'(s_ready), 128'((done_at < 0) && (q.size() < DEPTH) && !reset));
      chk("busy", 128'(busy), 128'(done_at >= 0));
      chk("m_valid", 128'(m_valid), 128'(q.size() > 0));
      if (q.size() > 0) begin
        chk("m_data", m_data, q[0].ct);
        chk("m_tag", 128'(m_tag), 128'(q[0].tag));
      end
      chk("blk_count", 128'(blk_count), 128'(mblk % (1 << CNTW)));
      chk("core_pt", core_pt, mpt);
      chk("core_key", core_key, mkey);
    end
  end

  task automatic send(input logic [127:0] pt, input logic [127:0] key,
                      input logic [3:0] tag, output int acc);
    int t;
    t = 0;
    s_valid = 1'b1; s_data = pt; s_key = key; s_tag = tag;
    while (!s_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      nchk++; nerr++;
      $display("FAIL send_timeout: s_ready got 0 expected 1");
    end
    acc = ecnt;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_mv(output int pe, output int bn);
    int t;
    t = 0; bn = 0;
    while (!m_valid && t < 200) begin
      bn += int'(busy);
      @(negedge clk);
      t++;
    end
    if (!m_valid) begin
      nchk++; nerr++;
      $display("FAIL wait_mvalid_timeout: m_valid got 0 expected 1");
    end
    pe = ecnt - 1;
  endtask

  int a0, a1, pe, bn;
  bit seen;

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_key = '0; s_tag = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_blk_count", 128'(blk_count), 128'd0);
    chk("rst_m_valid", 128'(m_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_s_ready", 128'(s_ready), 128'd1);

    // Known vector, first block pays key settle
    send(P1, K1, 4'd3, a0);
    wait_mv(pe, bn);
    chk("t1_latency", 128'(pe - a0), 128'd62);
    chk("t1_busy_cycles", 128'(bn), 128'd62);
    chk("t1_m_data", m_data, C1);
    chk("t1_m_tag", 128'(m_tag), 128'd3);
    chk("t1_blk_count", 128'(blk_count), 128'd1);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;

    // Same key: data settle only
    send('0, K1, 4'd5, a0);
    wait_mv(pe, bn);
    chk("t2_latency", 128'(pe - a0), 128'd50);
    chk("t2_m_tag", 128'(m_tag), 128'd5);

    // Key change, inputs wiggled during WAIT
    m_ready = 1'b1;
    send(128'h0123456789abcdef_fedcba9876543210, '0, 4'd7, a1);
    chk("t2_accept_spacing", 128'(a1 - a0), 128'd51);
    m_ready = 1'b0;
    s_data = {4{32'hcafef00d}}; s_key = {4{32'h13572468}}; s_tag = 4'hf;
    wait_mv(pe, bn);
    chk("t3_latency", 128'(pe - a1), 128'd62);
    chk("t3_m_tag", 128'(m_tag), 128'd7);
    chk("t3_m_data", m_data, core_fn(128'h0123456789abcdef_fedcba9876543210, '0));
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;

    // Fill the FIFO with the consumer stalled, then drain
    for (int i = 1; i <= 4; i++) send({32'(i), 96'h1}, '0, 4'(i), a0);
    for (int t = 0; t < 100 && busy; t++) @(negedge clk);
    chk("t4_full_s_ready", 128'(s_ready), 128'd0);
    chk("t4_head_tag", 128'(m_tag), 128'd1);
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t4_drain_valid", 128'(m_valid), 128'd1);
      chk("t4_drain_tag", 128'(m_tag), 128'(i));
      @(negedge clk);
      if (i == 1) chk("t4_s_ready_after_pop", 128'(s_ready), 128'd1);
    end
    m_ready = 1'b0;
    chk("t4_empty", 128'(m_valid), 128'd0);

    // Reset in the middle of WAIT
    send(128'h5555, '0, 4'd9, a0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_m_valid", 128'(m_valid), 128'd0);
    chk("t5_blk_count", 128'(blk_count), 128'd0);
    chk("t5_busy", 128'(busy), 128'd0);
    seen = 0;
    for (int t = 0; t < 70; t++) begin
      @(negedge clk);
      if (m_valid) seen = 1;
    end
    chk("t5_no_result", 128'(seen), 128'd0);
    send(128'h5555, '0, 4'd9, a0);
    wait_mv(pe, bn);
    chk("t5_latency", 128'(pe - a0), 128'd62);
    chk("t5_blk_after", 128'(blk_count), 128'd1);

    // Pop and push on the same edge with one entry queued
    send(128'h6666, '0, 4'd10, a0);
    repeat (49) @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("t6_m_valid", 128'(m_valid), 128'd1);
    chk("t6_m_tag", 128'(m_tag), 128'd10);
    chk("t6_blk_count", 128'(blk_count), 128'd2);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("t6_single_entry", 128'(m_valid), 128'd0);

    // Run the block counter past its wrap point
    m_ready = 1'b1;
    for (int i = 0; i < 15; i++) send({96'h0, 32'(i * 7 + 1)}, '0, 4'(i), a0);
    for (int t = 0; t < 100 && busy; t++) @(negedge clk);
    chk("wrap_blk_count", 128'(blk_count), 128'd1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
Streaming controller around the existing AES key-expansion and encrypt datapath, which is treated as a settling core. It replaces the fixed 50-cycle "plaintext-unchanged" counter with a valid/ready input and output interface. The settle time is parametrised, and it is shortened when the key is unchanged. Results pass through an output FIFO together with a user tag. The block sits between the host/bus adapter and the AES core; the core is instantiated outside this block.

Parameters:
BLK_W, 128, block width in bits (plaintext/ciphertext)
KEY_W, 128, key width in bits (128/192/256 core variants)
SETTLE_DATA, 50, cycles from plaintext change to valid core_ct (min 1)
SETTLE_KEY, 12, extra cycles added when key changes (min 0)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
TAG_W, 4, user tag width
CNT_W, 16, completed-block counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  input block valid
s_ready  out  1  input block accepted when s_valid && s_ready at posedge
s_data  in  BLK_W  plaintext
s_key  in  KEY_W  key
s_tag  in  TAG_W  user tag, returned with result
core_pt  out  BLK_W  plaintext held to core
core_key  out  KEY_W  key held to core
core_ct  in  BLK_W  core ciphertext (combinational/settling)
m_valid  out  1  output FIFO non-empty
m_ready  in  1  output consumer ready
m_data  out  BLK_W  ciphertext at FIFO head
m_tag  out  TAG_W  tag at FIFO head
busy  out  1  high in WAIT state
blk_count  out  CNT_W  blocks written into FIFO, wraps modulo 2^CNT_W

Behaviour:
- Reset state: state=IDLE; core_pt=0; core_key=0; key_loaded=0; FIFO empty; m_valid=0; busy=0; blk_count=0.
- Output FIFO storage contents are don't-care after reset.
- s_ready is combinational: (state==IDLE) && (fifo_count<FIFO_DEPTH) && !reset.
- States: IDLE, WAIT.
- IDLE, on accept at edge E0:
  - core_pt<=s_data; core_key<=s_key; tag_r<=s_tag.
  - key_chg = !key_loaded || (s_key != core_key).
  - N = SETTLE_DATA + (key_chg ? SETTLE_KEY : 0); cnt<=N-1; key_loaded<=1; go to WAIT.
- WAIT: cnt decrements each cycle. When cnt==0 at edge E0+N:
  - push {core_ct, tag_r} into FIFO; blk_count++; go to IDLE.
- Latency: result pushed at edge E0+N, so m_valid (if FIFO was empty) is high in the cycle after E0+N.
- Next accept is possible at E0+N+1 at the earliest. Throughput is one block per N+1 cycles. Only one block is in flight.
- The push never finds the FIFO full, because accept requires count<DEPTH and only pops occur during WAIT.
- Inputs s_data/s_key/s_tag are sampled only on accept; changes during WAIT are ignored. core_pt/core_key stay stable throughout WAIT and IDLE.
- FIFO is first-word-fall-through:
  - m_data/m_tag show the head entry and stay stable while m_valid && !m_ready.
  - A pop occurs on m_valid && m_ready.
  - Push and pop in the same cycle: count unchanged; order preserved; an empty FIFO never pops a same-cycle push.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- Reset during WAIT:
  - the pending capture is abandoned; FIFO is cleared; key_loaded=0.
  - the next block pays the full SETTLE_DATA+SETTLE_KEY.
- blk_count wraps from 2^CNT_W-1 to 0.

Decomposition:
- Package aes_ctrl_pkg: state enum (IDLE, WAIT); default SETTLE_DATA/SETTLE_KEY constants; helper function for counter width.
- Sub-module aes_out_fifo: synchronous FWFT FIFO parametrised on width (BLK_W+TAG_W) and depth. It exposes push, pop, full, empty and count.
- The FSM, counter and key compare stay in the top module.

Test Plan:
1. Reset, then accept key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, tag 3 -> busy for 62 cycles; m_valid rises 62 cycles after the accept edge; m_data=69c4e0d86a7b0430d8cdb78070b4c55a; m_tag=3; blk_count=1.
2. Same key, pt all-zero, tag 5 -> result pushed exactly 50 cycles after accept; s_ready low throughout WAIT; next accept possible 51 cycles after the previous one.
3. Change key to all-zero, then change s_data/s_key during WAIT -> latency 62; result matches the values sampled at accept.
4. m_ready=0, four back-to-back blocks with tags 1..4 -> s_ready=0 after the fourth push (count=4); m_data holds tag-1 result. Raise m_ready -> entries leave in order 1..4 and s_ready returns after the first pop.
5. Assert reset for 1 cycle at cycle 20 of WAIT -> no m_valid, blk_count=0; next block takes 62 cycles.
6. FIFO count=1 with m_ready=1 on the capture edge -> pop and push in the same cycle; count stays 1; ordering intact; blk_count increments.
